// File: rtl/ifu_fetch_if.sv
// Fetch-stage port bundle: redirect input, imem request/response channels and
// the instruction channel towards decode. The master modport is the fetch stage.
interface ifu_fetch_if;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  modport master (
    input  redirect_i,
    input  redirect_addr_i,
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_req_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    output inst_valid_o,
    input  inst_ready_i,
    output inst_o,
    output inst_addr_o
  );

  modport slave (
    output redirect_i,
    output redirect_addr_i,
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_req_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    input  inst_valid_o,
    output inst_ready_i,
    input  inst_o,
    input  inst_addr_o
  );
endinterface

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch stage. Owns the PC, issues in-order word reads,
// keeps returned words in a small in-order queue (entry allocated at request
// accept, filled at response) and hands {inst, inst_addr} to decode.
// A redirect flushes the queue; responses still in flight at that point are
// counted in drop_cnt_r and discarded when they arrive.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]   NOP_INST = 32'h0000_0013;
  localparam logic [31:0]   PC_MASK  = 32'hFFFF_FFFC;

  // Queue storage and bookkeeping
  logic [31:0]           q_addr_r [FIFO_DEPTH];
  logic [31:0]           q_data_r [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_filled_r;
  logic [AW-1:0]         head_r;
  logic [AW-1:0]         tail_r;
  logic [AW-1:0]         fill_ptr_r;
  logic [CW-1:0]         used_r;
  logic [CW-1:0]         unfilled_r;
  logic [CW-1:0]         drop_cnt_r;
  logic [31:0]           pc_r;

  // Control decode
  logic        credit_s;
  logic        req_valid_s;
  logic        accept_s;
  logic        head_valid_s;
  logic        pop_s;
  logic        rsp_drop_s;
  logic        rsp_fill_s;
  logic [CW:0] outstanding_s;
  logic [CW:0] redirect_drop_s;
  logic [31:0] redirect_pc_s;
  logic [31:0] inst_s;
  logic [31:0] inst_addr_s;

  // Handshake decode: credit, accept, pop, and how the current response is used
  always_comb begin
    credit_s      = ({1'b0, used_r} + {1'b0, drop_cnt_r}) < DEPTH_W;
    req_valid_s   = !rst && !bus.redirect_i && credit_s;
    accept_s      = req_valid_s && bus.imem_req_ready_i;
    head_valid_s  = (used_r != {CW{1'b0}}) && q_filled_r[head_r];
    pop_s         = head_valid_s && bus.inst_ready_i && !bus.redirect_i;
    rsp_drop_s    = bus.imem_rsp_valid_i && (drop_cnt_r != {CW{1'b0}});
    rsp_fill_s    = bus.imem_rsp_valid_i && (drop_cnt_r == {CW{1'b0}}) &&
                    (unfilled_r != {CW{1'b0}});
    redirect_pc_s = bus.redirect_addr_i & PC_MASK;
    // Every response still owed after a redirect must be dropped exactly once;
    // a response arriving in the redirect cycle itself is already accounted for.
    outstanding_s = {1'b0, drop_cnt_r} + {1'b0, unfilled_r};
    if (bus.imem_rsp_valid_i && (outstanding_s != {(CW + 1){1'b0}})) begin
      redirect_drop_s = outstanding_s - (CW + 1)'(1);
    end else begin
      redirect_drop_s = outstanding_s;
    end
  end

  // Decode-facing outputs: NOP and zero address whenever no valid head
  always_comb begin
    if (head_valid_s) begin
      inst_s      = q_data_r[head_r];
      inst_addr_s = q_addr_r[head_r];
    end else begin
      inst_s      = NOP_INST;
      inst_addr_s = 32'h0000_0000;
    end
  end

  assign bus.imem_req_valid_o = req_valid_s;
  assign bus.imem_req_addr_o  = pc_r;
  assign bus.inst_valid_o     = head_valid_s;
  assign bus.inst_o           = inst_s;
  assign bus.inst_addr_o      = inst_addr_s;

  // PC, queue pointers, counters and entry state; redirect flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC & PC_MASK;
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
      fill_ptr_r <= {AW{1'b0}};
      used_r     <= {CW{1'b0}};
      unfilled_r <= {CW{1'b0}};
      drop_cnt_r <= {CW{1'b0}};
      q_filled_r <= {FIFO_DEPTH{1'b0}};
    end else if (bus.redirect_i) begin
      pc_r       <= redirect_pc_s;
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
      fill_ptr_r <= {AW{1'b0}};
      used_r     <= {CW{1'b0}};
      unfilled_r <= {CW{1'b0}};
      drop_cnt_r <= redirect_drop_s[CW-1:0];
      q_filled_r <= {FIFO_DEPTH{1'b0}};
    end else begin
      if (accept_s) begin
        pc_r               <= pc_r + 32'd4;
        q_addr_r[tail_r]   <= pc_r;
        q_filled_r[tail_r] <= 1'b0;
        tail_r             <= tail_r + AW'(1);
      end
      if (rsp_fill_s) begin
        q_data_r[fill_ptr_r]   <= bus.imem_rsp_data_i;
        q_filled_r[fill_ptr_r] <= 1'b1;
        fill_ptr_r             <= fill_ptr_r + AW'(1);
      end
      if (pop_s) begin
        head_r <= head_r + AW'(1);
      end
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - CW'(1);
      end
      used_r     <= used_r + CW'(accept_s) - CW'(pop_s);
      unfilled_r <= unfilled_r + CW'(accept_s) - CW'(rsp_fill_s);
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: an in-order instruction memory model with
// one-cycle latency (responses can be held back), request/delivery logs and
// hand-computed expected address sequences.
module tb_ifu_fetch;

  logic clk;
  logic rst;
  ifu_fetch_if bus();

  ifu_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] pending  [$];
  logic [31:0] reqlog   [$];
  logic [31:0] delivered[$];
  logic        hold;
  int          cyc;
  int          first_deliv;
  int          first_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample handshakes, advance model.
  task automatic cycle();
    logic acc;
    logic rsp;
    logic [31:0] acc_addr;
    bus.imem_rsp_valid_i = !hold && (pending.size() > 0) && !rst;
    bus.imem_rsp_data_i  = bus.imem_rsp_valid_i ? mem_word(pending[0]) : 32'h0000_0000;
    #1;
    acc      = bus.imem_req_valid_o && bus.imem_req_ready_i;
    acc_addr = bus.imem_req_addr_o;
    rsp      = bus.imem_rsp_valid_i;
    if (bus.inst_valid_o && bus.inst_ready_i && !bus.redirect_i) begin
      delivered.push_back(bus.inst_addr_o);
      check("inst_data", bus.inst_o, mem_word(bus.inst_addr_o));
      if (first_deliv < 0) first_deliv = cyc;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      pending.delete();
    end else begin
      if (rsp) void'(pending.pop_front());
      if (acc) begin
        pending.push_back(acc_addr);
        reqlog.push_back(acc_addr);
        if (first_req < 0) first_req = cyc;
      end
    end
    bus.redirect_i = 1'b0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_i = 1'b0;
    #1;
    check("rst_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd0);
    cycle();
    rst = 1'b0;
    reqlog.delete();
    delivered.delete();
    cyc = 0;
    first_deliv = -1;
    first_req = -1;
  endtask

  task automatic redirect(input logic [31:0] a);
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = a;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    bus.redirect_i       = 1'b0;
    bus.redirect_addr_i  = 32'h0000_0000;
    bus.imem_req_ready_i = 1'b1;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'h0000_0000;
    bus.inst_ready_i     = 1'b1;
    cyc = 0;
    first_deliv = -1;
    first_req = -1;

    // Test 1: streaming fetch in order, reset state first
    do_reset();
    #1;
    check("t1_rst_inst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    check("t1_rst_inst", bus.inst_o, 32'h0000_0013);
    check("t1_rst_inst_addr", bus.inst_addr_o, 32'h0000_0000);
    check("t1_rst_req_addr", bus.imem_req_addr_o, 32'h0000_0000);
    check("t1_rst_req_valid", {31'd0, bus.imem_req_valid_o}, 32'd1);
    run(12);
    check("t1_first_req_cyc", first_req, 32'd0);
    check("t1_first_deliv_cyc", first_deliv, 32'd2);
    for (int i = 0; i < 4; i++) begin
      check("t1_req_addr", qget(reqlog, i), 32'(i * 4));
      check("t1_deliv_addr", qget(delivered, i), 32'(i * 4));
    end

    // Test 2: decode stalled from the start, queue fills with 0 and 4
    bus.inst_ready_i = 1'b0;
    do_reset();
    run(6);
    check("t2_req_count", reqlog.size(), 32'd2);
    #1;
    check("t2_req_valid_low", {31'd0, bus.imem_req_valid_o}, 32'd0);
    check("t2_head_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    check("t2_head_inst", bus.inst_o, mem_word(32'h0000_0000));
    check("t2_head_addr", bus.inst_addr_o, 32'h0000_0000);
    bus.inst_ready_i = 1'b1;
    run(6);
    check("t2_deliv0", qget(delivered, 0), 32'h0000_0000);
    check("t2_deliv1", qget(delivered, 1), 32'h0000_0004);
    check("t2_req2", qget(reqlog, 2), 32'h0000_0008);

    // Test 3: redirect with two responses in flight
    do_reset();
    hold = 1'b1;
    run(3);
    check("t3_inflight", reqlog.size(), 32'd2);
    redirect(32'h0000_0100);
    hold = 1'b0;
    run(8);
    check("t3_req_after_redirect", qget(reqlog, 2), 32'h0000_0100);
    check("t3_deliv0", qget(delivered, 0), 32'h0000_0100);
    check("t3_deliv1", qget(delivered, 1), 32'h0000_0104);

    // Test 4: redirect coinciding with a response and a ready memory
    do_reset();
    run(1);
    bus.redirect_i      = 1'b1;
    bus.redirect_addr_i = 32'h0000_0203;
    #1;
    check("t4_no_req_in_redirect", {31'd0, bus.imem_req_valid_o}, 32'd0);
    cycle();
    run(6);
    check("t4_req0", qget(reqlog, 0), 32'h0000_0000);
    check("t4_req1", qget(reqlog, 1), 32'h0000_0200);
    check("t4_deliv0", qget(delivered, 0), 32'h0000_0200);
    check("t4_deliv1", qget(delivered, 1), 32'h0000_0204);

    // Test 5: reset with a full queue
    bus.inst_ready_i = 1'b0;
    do_reset();
    run(5);
    #1;
    check("t5_full_head_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    do_reset();
    #1;
    check("t5_inst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    check("t5_inst", bus.inst_o, 32'h0000_0013);
    check("t5_inst_addr", bus.inst_addr_o, 32'h0000_0000);
    check("t5_req_addr", bus.imem_req_addr_o, 32'h0000_0000);
    bus.inst_ready_i = 1'b1;

    // Test 6: PC wraps from the top of the address space
    do_reset();
    redirect(32'hFFFF_FFFC);
    run(8);
    check("t6_req0", qget(reqlog, 0), 32'hFFFF_FFFC);
    check("t6_req1", qget(reqlog, 1), 32'h0000_0000);
    check("t6_deliv0", qget(delivered, 0), 32'hFFFF_FFFC);
    check("t6_deliv1", qget(delivered, 1), 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
